// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory-port arbiter.
//   state_t        - arbiter FSM states (idle / request to memory / wait response)
//   owner_t        - which requester owns the in-flight transaction
//   STARVE_MAX_DEF - default number of consecutive contested LS grants
//                    before fetch is forced through
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: grant selection between fetch (IF) and load/store (LS).
// LS wins contested cycles until STARVE_MAX contested LS grants in a row
// have been made; then IF is forced through once.
//   clk, rst_n          - clock, async active-low reset
//   if_valid, ls_valid  - requester valids
//   arb_en              - arbitration allowed (arbiter idle)
//   taken               - a grant is being consumed this cycle
//   gnt_if, gnt_ls      - one-hot (or zero) combinational grants
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_valid,
    input  logic ls_valid,
    input  logic arb_en,
    input  logic taken,
    output logic gnt_if,
    output logic gnt_ls
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == STARVE_LIM);
    assign gnt_if  = arb_en && if_valid && (!ls_valid || starved);
    assign gnt_ls  = arb_en && ls_valid && !gnt_if;

    // Only contested LS grants count; an uncontested LS grant or any IF
    // grant means fetch is not being starved, so the count restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (taken) begin
            if (gnt_if) begin
                starve_cnt <= '0;
            end else if (gnt_ls && if_valid) begin
                if (!starved) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one memory port between instruction fetch and the
// load/store unit. One transaction in flight at a time:
//   IDLE  arbitrate, latch the winner's request (ready pulses combinationally)
//   REQ   present the request until mem_req_ready
//   WAIT  route the memory response back to the owner as a 1-cycle pulse
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   if_req_valid/if_addr/if_req_ready       fetch request
//   if_rsp_valid/if_rsp_data                fetch response
//   ls_req_valid/ls_wren/ls_addr/ls_wdata/ls_wmask/ls_req_ready  LS request
//   ls_rsp_valid/ls_rsp_data                LS response (data 0 for stores)
//   mem_req_valid/mem_req_ready/mem_wren/mem_addr/mem_wdata/mem_wmask  memory request
//   mem_rsp_valid/mem_rsp_data              memory response
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req_valid,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_req_ready,
    output logic            if_rsp_valid,
    output logic [XLEN-1:0] if_rsp_data,
    input  logic            ls_req_valid,
    input  logic            ls_wren,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_req_ready,
    output logic            ls_rsp_valid,
    output logic [XLEN-1:0] ls_rsp_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic            mem_wren,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data
);

    // Memory is addressed in aligned 8-byte words.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(7);

    state_t state;
    owner_t owner;
    logic   gnt_if;
    logic   gnt_ls;
    logic   arb_en;

    assign arb_en       = (state == ST_IDLE);
    assign if_req_ready = gnt_if;
    assign ls_req_ready = gnt_ls;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .arb_en   (arb_en),
        .taken    (gnt_if || gnt_ls),
        .gnt_if   (gnt_if),
        .gnt_ls   (gnt_ls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            owner         <= OWN_IF;
            mem_req_valid <= 1'b0;
            mem_wren      <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            if_rsp_valid  <= 1'b0;
            if_rsp_data   <= '0;
            ls_rsp_valid  <= 1'b0;
            ls_rsp_data   <= '0;
        end else begin
            // Response strobes are single-cycle; rsp_data holds.
            if_rsp_valid <= 1'b0;
            ls_rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_if) begin
                        owner         <= OWN_IF;
                        mem_addr      <= if_addr & ALIGN_MASK;
                        mem_wdata     <= '0;
                        mem_wmask     <= '0;
                        mem_wren      <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state         <= ST_REQ;
                    end else if (gnt_ls) begin
                        owner         <= OWN_LS;
                        mem_addr      <= ls_addr & ALIGN_MASK;
                        mem_wdata     <= ls_wdata;
                        // Loads never carry a byte mask to memory.
                        mem_wmask     <= ls_wren ? ls_wmask : 8'h00;
                        mem_wren      <= ls_wren;
                        mem_req_valid <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (owner == OWN_IF) begin
                            if_rsp_valid <= 1'b1;
                            if_rsp_data  <= mem_rsp_data;
                        end else begin
                            ls_rsp_valid <= 1'b1;
                            ls_rsp_data  <= mem_wren ? '0 : mem_rsp_data;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with a transaction-level model
// and a reactive 1-cycle memory.
module tb_mem_arb;

    localparam int XLEN = 64;
    localparam int SM   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            if_req_valid = 1'b0;
    logic [XLEN-1:0] if_addr = '0;
    logic            if_req_ready;
    logic            if_rsp_valid;
    logic [XLEN-1:0] if_rsp_data;
    logic            ls_req_valid = 1'b0;
    logic            ls_wren = 1'b0;
    logic [XLEN-1:0] ls_addr = '0;
    logic [XLEN-1:0] ls_wdata = '0;
    logic [7:0]      ls_wmask = '0;
    logic            ls_req_ready;
    logic            ls_rsp_valid;
    logic [XLEN-1:0] ls_rsp_data;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b1;
    logic            mem_wren;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_rsp_valid = 1'b0;
    logic [XLEN-1:0] mem_rsp_data = '0;

    always #5 clk = ~clk;

    mem_arb #(.XLEN(XLEN), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_wren(ls_wren), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: one pinned word, everything else derived from address.
    function automatic logic [63:0] rdata(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0010) return 64'h1122334455667788;
        return {a[31:0], ~a[31:0]};
    endfunction

    // ---------------- memory responder ----------------
    logic            stray = 1'b0;
    logic            mute = 1'b0;
    logic            r_hs, r_st;
    logic [XLEN-1:0] r_a;
    initial begin
        forever begin
            @(negedge clk);
            r_hs = rst_n && mem_req_valid && mem_req_ready && !mute;
            r_st = stray;
            r_a  = mem_addr;
            @(posedge clk);
            #1;
            mem_rsp_valid = r_hs || r_st;
            mem_rsp_data  = rdata(r_a);
        end
    end

    // ---------------- transaction-level model ----------------
    // m_pend: a transaction has been accepted and not yet answered.
    // m_sent: it has been handed to memory.
    logic            m_pend = 0, m_sent = 0, m_own_ls = 0, m_wren = 0;
    logic [XLEN-1:0] m_addr = '0, m_wdata = '0, m_dif = '0, m_dls = '0;
    logic [7:0]      m_wmask = '0;
    int              m_cnt = 0;
    logic            m_pif = 0, m_pls = 0;
    logic            e_if, e_ls, gi, gl;

    always_comb begin
        e_if = !m_pend && if_req_valid && (!ls_req_valid || m_cnt == SM);
        e_ls = !m_pend && ls_req_valid && !e_if;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_sent = 0; m_own_ls = 0; m_wren = 0;
            m_addr = '0; m_wdata = '0; m_wmask = '0; m_cnt = 0;
            m_pif = 0; m_pls = 0; m_dif = '0; m_dls = '0;
        end else begin
            gi = e_if;
            gl = e_ls;
            m_pif = 0;
            m_pls = 0;
            if (m_pend && m_sent) begin
                if (mem_rsp_valid) begin
                    if (m_own_ls) begin
                        m_pls = 1;
                        m_dls = m_wren ? '0 : rdata(m_addr);
                    end else begin
                        m_pif = 1;
                        m_dif = rdata(m_addr);
                    end
                    m_pend = 0;
                end
            end else if (m_pend) begin
                if (mem_req_ready) m_sent = 1;
            end else if (gi) begin
                m_pend = 1; m_sent = 0; m_own_ls = 0;
                m_addr = if_addr & ~64'h7; m_wren = 0; m_wmask = '0;
                m_cnt = 0;
            end else if (gl) begin
                m_pend = 1; m_sent = 0; m_own_ls = 1;
                m_addr = ls_addr & ~64'h7; m_wren = ls_wren;
                m_wmask = ls_wren ? ls_wmask : 8'h00; m_wdata = ls_wdata;
                m_cnt = if_req_valid ? ((m_cnt < SM) ? m_cnt + 1 : SM) : 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("if_req_ready", 64'(if_req_ready), 64'(e_if));
        chk("ls_req_ready", 64'(ls_req_ready), 64'(e_ls));
        chk("mem_req_valid", 64'(mem_req_valid), 64'(m_pend && !m_sent));
        chk("if_rsp_valid", 64'(if_rsp_valid), 64'(m_pif));
        chk("ls_rsp_valid", 64'(ls_rsp_valid), 64'(m_pls));
        chk("if_rsp_data", if_rsp_data, m_dif);
        chk("ls_rsp_data", ls_rsp_data, m_dls);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wmask", 64'(mem_wmask), 64'(m_wmask));
        chk("mem_wren", 64'(mem_wren), 64'(m_wren));
        if (m_pend && !m_sent && m_wren) chk("mem_wdata", mem_wdata, m_wdata);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] gseq;
    int         ng;
    logic       found;

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_if_rsp_data", if_rsp_data, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single load, 1-cycle memory: accept at 0, rsp pulse at 3.
        ls_req_valid = 1; ls_wren = 0; ls_addr = 64'h8000_0013;
        ls_wdata = 64'hDEAD; ls_wmask = 8'hFF;
        @(negedge clk); chk("ld_accept", 64'(ls_req_ready), 64'h1);
        tick(); ls_req_valid = 0;
        @(negedge clk);
        chk("ld_mem_valid", 64'(mem_req_valid), 64'h1);
        chk("ld_mem_addr", mem_addr, 64'h8000_0010);
        chk("ld_mem_wmask", 64'(mem_wmask), 64'h0);
        tick();
        @(negedge clk); chk("ld_no_early_rsp", 64'(ls_rsp_valid), 64'h0);
        tick();
        @(negedge clk);
        chk("ld_rsp_valid", 64'(ls_rsp_valid), 64'h1);
        chk("ld_rsp_data", ls_rsp_data, 64'h1122334455667788);
        chk("ld_if_quiet", 64'(if_rsp_valid), 64'h0);
        tick();
        @(negedge clk);
        chk("ld_pulse_end", 64'(ls_rsp_valid), 64'h0);
        chk("ld_data_hold", ls_rsp_data, 64'h1122334455667788);

        // Store.
        tick();
        ls_req_valid = 1; ls_wren = 1; ls_addr = 64'h8000_0008;
        ls_wdata = 64'hAB00; ls_wmask = 8'h02;
        @(negedge clk); chk("st_accept", 64'(ls_req_ready), 64'h1);
        tick(); ls_req_valid = 0; ls_wren = 0;
        @(negedge clk);
        chk("st_mem_wren", 64'(mem_wren), 64'h1);
        chk("st_mem_wmask", 64'(mem_wmask), 64'h02);
        chk("st_mem_wdata", mem_wdata, 64'hAB00);
        tick(); tick();
        @(negedge clk);
        chk("st_rsp_valid", 64'(ls_rsp_valid), 64'h1);
        chk("st_rsp_data", ls_rsp_data, 64'h0);

        // Both requesters held high: grant order L L L L I L L L L I.
        tick();
        if_req_valid = 1; if_addr = 64'h1000;
        ls_req_valid = 1; ls_wren = 0; ls_addr = 64'h2000;
        gseq = '0; ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge clk);
            if (if_req_ready || ls_req_ready) begin
                gseq[ng] = if_req_ready;
                ng++;
            end
            tick();
        end
        if_req_valid = 0; ls_req_valid = 0;
        chk("grant_count", 64'(ng), 64'd10);
        chk("grant_order", 64'(gseq), 64'(10'b1000010000));
        repeat (4) tick();

        // Memory stalls in REQ for 5 cycles.
        mem_req_ready = 0;
        if_req_valid = 1; if_addr = 64'h1234_5671;
        @(negedge clk); chk("stall_accept", 64'(if_req_ready), 64'h1);
        tick();
        ls_req_valid = 1; ls_wren = 0; ls_addr = 64'h3000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(mem_req_valid), 64'h1);
            chk("stall_addr", mem_addr, 64'h1234_5670);
            chk("stall_wmask", 64'(mem_wmask), 64'h0);
            chk("stall_if_rdy", 64'(if_req_ready), 64'h0);
            chk("stall_ls_rdy", 64'(ls_req_ready), 64'h0);
            tick();
        end
        mem_req_ready = 1;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            @(negedge clk);
            if (if_rsp_valid) found = 1;
            else tick();
        end
        chk("stall_complete", 64'(found), 64'h1);
        chk("stall_rsp_data", if_rsp_data, 64'h12345670EDCBA98F);
        tick();
        if_req_valid = 0; ls_req_valid = 0;
        repeat (5) tick();

        // Reset while in WAIT: no response, outputs back to reset values.
        mute = 1;
        ls_req_valid = 1; ls_wren = 0; ls_addr = 64'h8000_0040;
        @(negedge clk); chk("rw_accept", 64'(ls_req_ready), 64'h1);
        tick(); ls_req_valid = 0;
        tick(); tick();
        rst_n = 0;
        @(negedge clk);
        chk("rw_mem_valid", 64'(mem_req_valid), 64'h0);
        chk("rw_mem_addr", mem_addr, 64'h0);
        chk("rw_ls_rsp_data", ls_rsp_data, 64'h0);
        chk("rw_if_rsp_data", if_rsp_data, 64'h0);
        tick();
        rst_n = 1; mute = 0; stray = 1;
        tick(); stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw_no_ls_rsp", 64'(ls_rsp_valid), 64'h0);
            chk("rw_no_if_rsp", 64'(if_rsp_valid), 64'h0);
            tick();
        end
        ls_req_valid = 1; ls_addr = 64'h8000_0013;
        @(negedge clk); chk("rw_next_accept", 64'(ls_req_ready), 64'h1);
        tick(); ls_req_valid = 0;
        tick(); tick();
        @(negedge clk);
        chk("rw_next_rsp", 64'(ls_rsp_valid), 64'h1);
        chk("rw_next_data", ls_rsp_data, 64'h1122334455667788);

        // Stray memory response while idle.
        tick(); stray = 1;
        tick(); stray = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_no_ls", 64'(ls_rsp_valid), 64'h0);
            chk("stray_no_if", 64'(if_rsp_valid), 64'h0);
            tick();
        end
        if_req_valid = 1; if_addr = 64'h40;
        @(negedge clk); chk("stray_idle_accept", 64'(if_req_ready), 64'h1);
        tick(); if_req_valid = 0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
